// File: rtl/cache_ctrl_sa_wb.sv
// cache_ctrl_sa_wb: N-way set-associative, write-back, write-allocate cache controller.
// Holds the tag/valid/dirty/age arrays. Steers an external data array and a
// line-granular memory port. Sits between the CPU memory stage and main memory.
//
// Ports
//   CLK, reset            clock (rising edge), asynchronous active-high reset
//   rden, wen, addr       CPU request; rden&wen together is treated as a write
//   busy                  stall to CPU
//   hit                   one-cycle pulse when a request completes as a hit
//   way_sel               way for the data-array access or line fill
//   data_we               write the CPU word into the data array (way_sel, addr)
//   line_fill             load the memory line into the data array (way_sel, index)
//   mem_req, mem_we       memory request (held until mem_ready); 1=writeback, 0=fetch
//   mem_addr              line-aligned memory address
//   mem_ready             memory has finished the current line
//   hit_count, miss_count performance counters
//
// Build option: define CACHE_PERF_CNT_EN to enable the saturating hit/miss counters;
// without it both counters read 0 and no counter flops exist.
//
// Outputs are decoded from the registered state and arrays. The hit pulse and the
// miss stall must appear in the COMPARE cycle itself, and mem_req must drop as soon
// as reset is asserted.

module cache_ctrl_sa_wb #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    rden,
    input  logic                    wen,
    input  logic [ADDR_W-1:0]       addr,
    output logic                    busy,
    output logic                    hit,
    output logic [$clog2(WAYS)-1:0] way_sel,
    output logic                    data_we,
    output logic                    line_fill,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ready,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W = ADDR_W - OFF_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_REFILL    = 2'd3;

    logic [1:0]        state_q, state_d;

    // Latched request (line address only) and victim way
    logic [LINE_W-1:0] req_line_q;
    logic              req_we_q;
    logic [WAY_W-1:0]  victim_q;

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;

    logic              lookup_hit;
    logic [WAY_W-1:0]  lookup_way;
    logic              inv_found;
    logic [WAY_W-1:0]  victim_c;

    logic              latch_req, latch_victim, set_dirty, clr_dirty, fill, lru_upd;
    logic [WAY_W-1:0]  lru_way;

    // Byte offset is only meaningful to the external data array
    logic              unused_off_c;
    assign unused_off_c = ^addr[OFF_W-1:0];

    assign req_idx = req_line_q[IDX_W-1:0];
    assign req_tag = req_line_q[LINE_W-1 -: TAG_W];

    // Tag lookup and victim choice for the latched request
    always_comb begin
        lookup_hit = 1'b0;
        lookup_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                lookup_hit = 1'b1;
                lookup_way = WAY_W'(w);
            end
        end
        // Lowest-index invalid way first, otherwise the oldest way
        inv_found = 1'b0;
        victim_c  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                victim_c  = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) begin
                    victim_c = WAY_W'(w);
                end
            end
        end
    end

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, outputs and array-update strobes
    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        hit          = 1'b0;
        way_sel      = '0;
        data_we      = 1'b0;
        line_fill    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        latch_req    = 1'b0;
        latch_victim = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        fill         = 1'b0;
        lru_upd      = 1'b0;
        lru_way      = '0;
        case (state_q)
            S_IDLE: begin
                if (rden || wen) begin
                    latch_req = 1'b1;
                    state_d   = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (lookup_hit) begin
                    hit       = 1'b1;
                    way_sel   = lookup_way;
                    data_we   = req_we_q;
                    set_dirty = req_we_q;
                    lru_upd   = 1'b1;
                    lru_way   = lookup_way;
                    state_d   = S_IDLE;
                end else begin
                    busy         = 1'b1;
                    latch_victim = 1'b1;
                    if (valid_q[req_idx][victim_c] && dirty_q[req_idx][victim_c]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                way_sel  = victim_q;
                mem_addr = {tag_q[req_idx][victim_q], req_idx, OFF_W'(0)};
                if (mem_ready) begin
                    clr_dirty = 1'b1;
                    state_d   = S_REFILL;
                end
            end
            S_REFILL: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                way_sel  = victim_q;
                mem_addr = {req_line_q, OFF_W'(0)};
                if (mem_ready) begin
                    line_fill = 1'b1;
                    fill      = 1'b1;
                    lru_upd   = 1'b1;
                    lru_way   = victim_q;
                    state_d   = S_COMPARE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, tag/valid/dirty/age arrays
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            req_line_q <= '0;
            req_we_q   <= 1'b0;
            victim_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w] <= '0;
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            if (latch_req) begin
                req_line_q <= addr[ADDR_W-1:OFF_W];
                req_we_q   <= wen;
            end
            if (latch_victim) begin
                victim_q <= victim_c;
            end
            if (clr_dirty) begin
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (fill) begin
                tag_q[req_idx][victim_q]   <= req_tag;
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (set_dirty) begin
                dirty_q[req_idx][lookup_way] <= 1'b1;
            end
            // Ages stay a permutation: younger-than-touched ways grow older by one
            if (lru_upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (age_q[req_idx][w] < age_q[req_idx][lru_way]) begin
                        age_q[req_idx][w] <= age_q[req_idx][w] + WAY_W'(1);
                    end
                end
                age_q[req_idx][lru_way] <= '0;
            end
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic        retry_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating counters; the hit that follows a refill is the retry, not a new hit
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            retry_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (line_fill) begin
                retry_q <= 1'b1;
            end else if (hit) begin
                retry_q <= 1'b0;
            end
            if (hit && !retry_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == S_COMPARE) && !lookup_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_sa_wb.sv
// tb_cache_ctrl_sa_wb: scoreboard bench for cache_ctrl_sa_wb (WAYS=2, SETS=16, LINE_BYTES=16).
// A reference model (per-set resident lines with last-use timestamps) predicts the
// memory transactions, fills and hits of each request; a monitor compares them
// against what the DUT presents. A randomly timed memory responder serves requests.

module tb_cache_ctrl_sa_wb;

    localparam int unsigned WAYS       = 2;
    localparam int unsigned SETS       = 16;
    localparam int unsigned LINE_BYTES = 16;

    localparam int K_WB   = 0;
    localparam int K_RF   = 1;
    localparam int K_FILL = 2;
    localparam int K_HIT  = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        int          way;
        bit          we;
    } ev_t;

    logic        CLK, reset, rden, wen, mem_ready;
    logic [31:0] addr;
    logic        busy, hit, data_we, line_fill, mem_req, mem_we;
    logic [0:0]  way_sel;
    logic [31:0] mem_addr, hit_count, miss_count;

    int  checks = 0;
    int  errors = 0;
    bit  hold_refill = 1'b0;
    ev_t exp_q[$];

    // Reference model state
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    logic [31:0] m_line  [SETS][WAYS];
    longint      m_use   [SETS][WAYS];
    longint      m_tick;
    int          m_hits, m_misses;

    cache_ctrl_sa_wb #(
        .ADDR_W(32), .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES)
    ) dut (
        .CLK(CLK), .reset(reset), .rden(rden), .wen(wen), .addr(addr),
        .busy(busy), .hit(hit), .way_sel(way_sel), .data_we(data_we),
        .line_fill(line_fill), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    function automatic void push(input int kind, input logic [31:0] a, input int way, input bit we);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.way  = way;
        e.we   = we;
        exp_q.push_back(e);
    endfunction

    function automatic bit pop(input string name, output ev_t e);
        e = '{kind: -1, addr: 32'h0, way: -1, we: 1'b0};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=unexpected event required=none pending", name);
            return 1'b0;
        end
        e = exp_q.pop_front();
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_line[s][w]  = 32'h0;
                m_use[s][w]   = -longint'(w);
            end
        end
        m_tick   = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Predict the events of one request and update the model
    task automatic model_req(input logic [31:0] a, input bit we, output bit was_hit);
        int          idx, way, v;
        logic [31:0] line;
        idx  = int'((a >> 4) & 32'(SETS - 1));
        line = a & ~32'(LINE_BYTES - 1);
        way  = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[idx][w] && (m_line[idx][w] == line)) way = w;
        end
        was_hit = (way >= 0);
        if (was_hit) begin
            m_hits++;
        end else begin
            m_misses++;
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!m_valid[idx][w]) v = w;
            end
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < WAYS; w++) begin
                    if (m_use[idx][w] < m_use[idx][v]) v = w;
                end
            end
            if (m_valid[idx][v] && m_dirty[idx][v]) push(K_WB, m_line[idx][v], 0, 1'b0);
            push(K_RF, line, 0, 1'b0);
            push(K_FILL, 32'h0, v, 1'b0);
            m_line[idx][v]  = line;
            m_valid[idx][v] = 1'b1;
            m_dirty[idx][v] = 1'b0;
            way = v;
        end
        push(K_HIT, 32'h0, way, we);
        m_tick++;
        m_use[idx][way] = m_tick;
        if (we) m_dirty[idx][way] = 1'b1;
    endtask

    // Memory responder: random latency, occasional stray mem_ready while idle
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            mem_ready = 1'b0;
            if (mem_req) begin
                if (hold_refill && !mem_we) begin
                    wait_cnt = 0;
                end else if (wait_cnt == 0) begin
                    mem_ready = 1'b1;
                    wait_cnt  = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ready = 1'b1;
            end
        end
    end

    // Monitor: compare every observed event against the scoreboard queue
    initial begin : monitor
        ev_t         e;
        bit          pend;
        logic [31:0] paddr;
        logic        pwe;
        pend = 1'b0;
        paddr = 32'h0;
        pwe = 1'b0;
        forever begin
            @(negedge CLK);
            if (mem_req && pend) begin
                chk("mem_addr_stable", mem_addr, paddr);
                chk("mem_we_stable", 32'(mem_we), 32'(pwe));
            end
            pend  = mem_req && !mem_ready;
            paddr = mem_addr;
            pwe   = mem_we;
            if (mem_req && mem_ready) begin
                if (pop("mem_event", e)) begin
                    chk("mem_kind", mem_we ? 32'(K_WB) : 32'(K_RF), 32'(e.kind));
                    chk("mem_addr", mem_addr, e.addr);
                end
            end
            if (line_fill) begin
                if (pop("fill_event", e)) begin
                    chk("fill_kind", 32'(K_FILL), 32'(e.kind));
                    chk("fill_way", 32'(way_sel), 32'(e.way));
                end
            end
            if (hit) begin
                if (pop("hit_event", e)) begin
                    chk("hit_kind", 32'(K_HIT), 32'(e.kind));
                    chk("hit_way", 32'(way_sel), 32'(e.way));
                    chk("hit_data_we", 32'(data_we), 32'(e.we));
                end
                chk("busy_on_hit", 32'(busy), 32'd0);
            end
            if (data_we) chk("data_we_needs_hit", 32'(hit), 32'd1);
        end
    end

    task automatic check_counters(input string name);
`ifdef CACHE_PERF_CNT_EN
        chk({name, "_hit_count"}, hit_count, 32'(m_hits));
        chk({name, "_miss_count"}, miss_count, 32'(m_misses));
`else
        chk({name, "_hit_count"}, hit_count, 32'd0);
        chk({name, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    // Issue one request (called just after a rising edge) and wait for its hit
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a);
        bit eh, done;
        int n;
        model_req(a, wr, eh);
        rden = rd;
        wen  = wr;
        addr = a;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge CLK);
            n++;
            if (hit === 1'b1) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout addr=0x%0h actual=no hit required=hit within 200 cycles", a);
        end else if (eh) begin
            chk("hit_latency", 32'(n), 32'd2);
        end
        @(posedge CLK);
        #1;
        rden = 1'b0;
        wen  = 1'b0;
    endtask

    initial begin
        int          n, op;
        bit          h;
        logic [31:0] a;
        reset = 1'b1;
        rden  = 1'b0;
        wen   = 1'b0;
        addr  = 32'h0;
        model_reset();

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_way_sel", 32'(way_sel), 32'd0);
        chk("rst_data_we", 32'(data_we), 32'd0);
        chk("rst_line_fill", 32'(line_fill), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        @(posedge CLK);
        #1;
        reset = 1'b0;

        // Directed: cold fill, hits, dirty eviction, read+write as write
        do_req(1'b1, 1'b0, 32'h0000_0100);
        do_req(1'b1, 1'b0, 32'h0000_0104);
        do_req(1'b0, 1'b1, 32'h0000_0100);
        do_req(1'b1, 1'b0, 32'h0000_1100);
        do_req(1'b1, 1'b0, 32'h0000_0108);
        do_req(1'b1, 1'b1, 32'h0000_1104);
        do_req(1'b1, 1'b0, 32'h0000_2100);
        check_counters("directed");
        do_req(1'b1, 1'b0, 32'h0000_3100);

        // Reset while a refill is outstanding
        hold_refill = 1'b1;
        model_req(32'h0000_5100, 1'b0, h);
        rden = 1'b1;
        addr = 32'h0000_5100;
        n = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b0) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("refill_reached", 32'(mem_req && !mem_we), 32'd1);
        chk("refill_addr", mem_addr, 32'h0000_5100);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        model_reset();
        rden = 1'b0;
        hold_refill = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        do_req(1'b1, 1'b0, 32'h0000_0100);
        check_counters("after_reset");

        // Random traffic over a few conflicting lines per set
        for (int i = 0; i < 400; i++) begin
            a = (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 3)) << 4)
                | 32'($urandom_range(0, 15));
            op = $urandom_range(0, 2);
            do_req(op != 1, op != 0, a);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end

        @(negedge CLK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check_counters("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
